// File: rtl/fxp_pkg.sv
// Shared widths, infinity codes, FSM encoding and magnitude helpers for the
// sequential fixed-point multiplier.
package fxp_pkg;

    localparam int A_W   = 9;
    localparam int B_W   = 9;
    localparam int Q_I_W = 4;
    localparam int Q_F_W = 16;
    localparam int Q_W   = Q_I_W + Q_F_W;
    localparam int P_W   = Q_W + B_W;
    localparam int M_W   = P_W + 1 - Q_F_W;
    localparam int CNT_W = $clog2(B_W);

    localparam logic [Q_W-1:0] POS_INF = {1'b0, {(Q_W-1){1'b1}}};
    localparam logic [Q_W-1:0] NEG_INF = {1'b1, {(Q_W-2){1'b0}}, 1'b1};

    localparam logic [A_W-1:0] S_MAX = {1'b0, {(A_W-1){1'b1}}};
    localparam logic [A_W-1:0] S_MIN = {1'b1, {(A_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Unsigned magnitude; the most negative code maps onto its exact magnitude.
    function automatic logic [Q_W-1:0] mag_q(input logic [Q_W-1:0] v);
        return v[Q_W-1] ? (~v + Q_W'(1)) : v;
    endfunction

    function automatic logic [B_W-1:0] mag_b(input logic [B_W-1:0] v);
        return v[B_W-1] ? (~v + B_W'(1)) : v;
    endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Rounds the unsigned product magnitude, restores the sign and saturates to
// A_W bits; divider infinity codes override the arithmetic.
module fxp_round_sat
    import fxp_pkg::*;
(
    input  logic [P_W-1:0] acc,
    input  logic           sign,
    input  logic           inf,
    input  logic           b_zero,
    output logic [A_W-1:0] o,
    output logic           sat
);

    localparam logic [P_W:0]   RND_C   = (P_W+1)'(1) << (Q_F_W - 1);
    localparam logic [M_W-1:0] POS_LIM = M_W'(2**(A_W-1) - 1);
    localparam logic [M_W-1:0] NEG_LIM = M_W'(2**(A_W-1));

    logic [M_W-1:0] m_s;

    assign m_s = M_W'(({1'b0, acc} + RND_C) >> Q_F_W);

    // Saturation is decided on the magnitude so the negative limit stays exact.
    always_comb begin
        o   = {A_W{1'b0}};
        sat = 1'b0;
        if (inf) begin
            sat = 1'b1;
            if (b_zero) begin
                o = {A_W{1'b0}};
            end else if (sign) begin
                o = S_MIN;
            end else begin
                o = S_MAX;
            end
        end else if (!sign) begin
            if (m_s > POS_LIM) begin
                o   = S_MAX;
                sat = 1'b1;
            end else begin
                o = m_s[A_W-1:0];
            end
        end else begin
            if (m_s > NEG_LIM) begin
                o   = S_MIN;
                sat = 1'b1;
            end else begin
                o = (~m_s[A_W-1:0]) + A_W'(1);
            end
        end
    end

endmodule

// File: rtl/fxp_mul_seq.sv
// Sequential shift-add fixed-point multiplier, o = round_sat(q * b), with
// valid/ready handshakes on input and output.
module fxp_mul_seq
    import fxp_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [Q_W-1:0] q,
    input  logic [B_W-1:0] b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [A_W-1:0] o,
    output logic           sat
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(B_W - 1);

    state_t           state_r;
    state_t           state_s;
    logic             accept_s;
    logic             in_ready_s;
    logic             out_valid_s;
    logic [P_W-1:0]   mq_r;
    logic [B_W-1:0]   mb_r;
    logic [P_W-1:0]   acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             sign_r;
    logic             inf_r;
    logic             b_zero_r;
    logic [A_W-1:0]   rs_o_s;
    logic             rs_sat_s;

    assign accept_s = in_valid & in_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = CALC;
                else          state_s = IDLE;
            end
            CALC: begin
                if (cnt_r == CNT_LAST) state_s = FINAL;
                else                   state_s = CALC;
            end
            FINAL: state_s = DONE;
            DONE: begin
                if (out_ready && out_valid) state_s = IDLE;
                else                        state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // out_valid rises one cycle after entering DONE and drops on the leaving edge.
    always_comb begin
        in_ready_s  = (state_s == IDLE);
        out_valid_s = (state_r == DONE) && (state_s == DONE);
    end

    // Registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= in_ready_s;
            out_valid <= out_valid_s;
        end
    end

    fxp_round_sat u_round_sat (
        .acc    (acc_r),
        .sign   (sign_r),
        .inf    (inf_r),
        .b_zero (b_zero_r),
        .o      (rs_o_s),
        .sat    (rs_sat_s)
    );

    // Operand capture, shift-add iteration and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            mq_r     <= {P_W{1'b0}};
            mb_r     <= {B_W{1'b0}};
            acc_r    <= {P_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            sign_r   <= 1'b0;
            inf_r    <= 1'b0;
            b_zero_r <= 1'b0;
            o        <= {A_W{1'b0}};
            sat      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        mq_r     <= P_W'(mag_q(q));
                        mb_r     <= mag_b(b);
                        acc_r    <= {P_W{1'b0}};
                        cnt_r    <= {CNT_W{1'b0}};
                        sign_r   <= q[Q_W-1] ^ b[B_W-1];
                        inf_r    <= (q == POS_INF) || (q == NEG_INF);
                        b_zero_r <= (b == {B_W{1'b0}});
                    end
                end
                CALC: begin
                    if (mb_r[0]) begin
                        acc_r <= acc_r + mq_r;
                    end
                    mq_r  <= mq_r << 1;
                    mb_r  <= mb_r >> 1;
                    cnt_r <= cnt_r + CNT_W'(1);
                end
                FINAL: begin
                    o   <= rs_o_s;
                    sat <= rs_sat_s;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fxp_mul_seq.sv
// Self-checking bench for fxp_mul_seq: a signed-product reference model feeds
// a scoreboard queue that is compared when the DUT presents each result.
module tb_fxp_mul_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [19:0] q = 20'd0;
    logic [8:0]  b = 9'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [8:0]  o;
    logic        sat;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [9:0] sb[$];

    fxp_mul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q         (q),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o         (o),
        .sat       (sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: exact signed product, round half away from zero, saturate. Returns {o, sat}.
    function automatic logic [9:0] model(input logic [19:0] qv, input logic [8:0] bv);
        longint qs, bs, p, mag, m, r;
        logic [8:0] ov;
        qs = longint'($signed(qv));
        bs = longint'($signed(bv));
        if (qv == 20'h7FFFF || qv == 20'h80001) begin
            if (bs == 0) return {9'd0, 1'b1};
            if ((qv == 20'h7FFFF && bs > 0) || (qv == 20'h80001 && bs < 0)) return {9'd255, 1'b1};
            return {9'h100, 1'b1};
        end
        p   = qs * bs;
        mag = (p < 0) ? -p : p;
        m   = (mag + 64'sd32768) >>> 16;
        r   = (p < 0) ? -m : m;
        if (r > 255)  return {9'd255, 1'b1};
        if (r < -256) return {9'h100, 1'b1};
        ov = r[8:0];
        return {ov, 1'b0};
    endfunction

    task automatic start_op(input logic [19:0] qv, input logic [8:0] bv, output int acc_cyc);
        int n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
        end
        q = qv; b = bv; in_valid = 1'b1;
        @(posedge clk); #1;
        acc_cyc = cyc;
        sb.push_back(model(qv, bv));
        in_valid = 1'b0;
        q = 20'($urandom);
        b = 9'($urandom);
    endtask

    task automatic wait_valid(input int acc_cyc, input bit chk_lat);
        int n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL out_valid_timeout: out_valid=%b required 1", out_valid);
        end
        if (chk_lat) begin
            checks++;
            if (cyc - acc_cyc != 11) begin
                failures++;
                $display("FAIL latency: got %0d cycles required 11", cyc - acc_cyc);
            end
        end
    endtask

    task automatic compare_result(input string name);
        logic [9:0] exp;
        exp = (sb.size() > 0) ? sb.pop_front() : 10'h3FF;
        checks++;
        if ({o, sat} !== exp) begin
            failures++;
            $display("FAIL %s: o=%0d sat=%b required o=%0d sat=%b",
                     name, $signed(o), sat, $signed(exp[9:1]), exp[0]);
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic run_op(input logic [19:0] qv, input logic [8:0] bv, input string name);
        int ac;
        start_op(qv, bv, ac);
        wait_valid(ac, 1'b1);
        compare_result(name);
        release_out();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || o !== 9'd0 || sat !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b o=%0d sat=%b required 1/0/0/0",
                     in_ready, out_valid, o, sat);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int ac;
        run_op(20'h18000, 9'd6, "mul_1p5_x6");
        // out_ready held high before out_valid must not disturb the result
        out_ready = 1'b1;
        start_op(20'hF8000, 9'd5, ac);
        wait_valid(ac, 1'b1);
        compare_result("mul_m0p5_x5");
        release_out();
        run_op(20'h00000, 9'd77, "q_zero");
        run_op(20'h12345, 9'd0, "b_zero");
        run_op(20'h08000, 9'h1FD, "half_x_m3");
    endtask

    task automatic test_saturation();
        run_op(20'h70000, 9'd100, "sat_pos");
        run_op(20'h80000, 9'h100, "sat_minmin");
        run_op(20'h90000, 9'd100, "sat_neg");
        run_op(20'h80000, 9'd32, "exact_min");
    endtask

    task automatic test_infinity();
        run_op(20'h7FFFF, 9'h1FD, "posinf_neg_b");
        run_op(20'h7FFFF, 9'd0, "posinf_zero_b");
        run_op(20'h7FFFF, 9'd3, "posinf_pos_b");
        run_op(20'h80001, 9'h1FF, "neginf_neg_b");
        run_op(20'h80001, 9'd1, "neginf_pos_b");
    endtask

    task automatic test_hold();
        int ac;
        logic [9:0] exp;
        int bad = 0;
        start_op(20'h2C000, 9'd13, ac);
        wait_valid(ac, 1'b1);
        exp = (sb.size() > 0) ? sb[0] : 10'h3FF;
        compare_result("hold_first");
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; q = 20'h12345; b = 9'd7;
            @(posedge clk); #1;
            if ({o, sat} !== exp || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        in_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL hold_stable: %0d bad cycles required 0", bad);
        end
        release_out();
        run_op(20'h3A000, 9'd11, "after_hold");
    endtask

    task automatic test_reset_mid();
        int ac;
        int seen = 0;
        start_op(20'h50000, 9'd9, ac);
        void'(sb.pop_back());
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || o !== 9'd0 || sat !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: in_ready=%b out_valid=%b o=%0d sat=%b required 1/0/0/0",
                     in_ready, out_valid, o, sat);
        end
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL ghost_output: out_valid seen %0d cycles required 0", seen);
        end
        run_op(20'hE4000, 9'd21, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [19:0] qv;
        logic [8:0]  bv;
        for (int i = 0; i < 10; i++) begin
            qv = 20'($urandom);
            bv = 9'($urandom);
            if (i == 0) qv = 20'h80000;
            if (i == 1) bv = 9'h100;
            if (i < 4) qv = {{4{qv[19]}}, qv[15:0]} >>> 2;
            run_op(qv, bv, "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_infinity();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
